// File: rtl/jt03_seq_pkg.sv
// Shared types and constants for the YM2203 write sequencer.
package jt03_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ADR,
      GAP1,
      DAT,
      GAP2,
      POLL
   } state_t;

   localparam logic ADDR_PORT = 1'b0;
   localparam logic DATA_PORT = 1'b1;
   localparam int   BUSY_BIT  = 7;

   // Width of a counter that must hold values 0..n.
   function automatic int cnt_w(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/jt03_seq_fifo.sv
// Synchronous command FIFO with registered full/empty flags.
module jt03_seq_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_i,
   input  logic         pop_i,
   input  logic [W-1:0] wdata_i,
   output logic [W-1:0] rdata_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          full_q, empty_q;
   logic          do_push, do_pop;

   assign do_push = push_i & ~full_q;
   assign do_pop  = pop_i & ~empty_q;
   assign rdata_o = mem_q[rp_q];
   assign full_o  = full_q;
   assign empty_o = empty_q;

   // Occupancy next-state from the accepted push/pop pair.
   always_comb begin
      cnt_d = cnt_q;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // Pointers, count and flags; reset flushes the queue.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
      end else begin
         if (do_push) wp_q <= wp_q + 1'b1;
         if (do_pop)  rp_q <= rp_q + 1'b1;
         cnt_q   <= cnt_d;
         full_q  <= (cnt_d == (AW+1)'(DEPTH));
         empty_q <= (cnt_d == '0);
      end
   end

   // Storage needs no reset: the flags guard every read.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wp_q] <= wdata_i;
   end

endmodule

// File: rtl/jt03_wr_seq.sv
// YM2203 CPU-port write sequencer: queues (reg,val) commands, writes the
// address then data port, then polls busy. Optional register-address cache
// is enabled by defining JT03_SEQ_ADDR_CACHE_EN.
module jt03_wr_seq
   import jt03_seq_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STROBE       = 2,
   parameter int BUSY_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cen,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_reg,
   input  logic [7:0] cmd_val,
   output logic [7:0] ym_din,
   output logic       ym_addr,
   output logic       ym_cs_n,
   output logic       ym_wr_n,
   input  logic [7:0] ym_dout,
   output logic       idle,
   output logic       timeout
);

   localparam int SW = cnt_w(STROBE);
   localparam int PW = cnt_w(BUSY_TIMEOUT);
   localparam logic [SW-1:0] SLAST = SW'(STROBE - 1);
   localparam logic [PW-1:0] PLAST = PW'(BUSY_TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [SW-1:0] scnt_q, scnt_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [7:0]    cur_reg_q, cur_reg_d, cur_val_q, cur_val_d;
   logic [7:0]    din_q, din_d;
   logic          addr_q, addr_d, cs_n_q, cs_n_d, wr_n_q, wr_n_d;
   logic          idle_q, idle_d, timeout_q, timeout_d;
   logic          pop, start, leave, tmo_hit, hit;
   logic          full, empty, push_acc;
   logic [15:0]   head;
   logic          unused_dout;

   assign unused_dout = ^ym_dout[6:0];
   assign cmd_ready   = ~full;
   assign push_acc    = cmd_valid & ~full;

   assign ym_din  = din_q;
   assign ym_addr = addr_q;
   assign ym_cs_n = cs_n_q;
   assign ym_wr_n = wr_n_q;
   assign idle    = idle_q;
   assign timeout = timeout_q;

   jt03_seq_fifo #(.DEPTH(FIFO_DEPTH), .W(16)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (cmd_valid),
      .pop_i   (pop),
      .wdata_i ({cmd_reg, cmd_val}),
      .rdata_o (head),
      .full_o  (full),
      .empty_o (empty)
   );

`ifdef JT03_SEQ_ADDR_CACHE_EN
   logic [7:0] last_reg_q;
   logic       cache_vld_q;

   // Remember the last register latched by a finished address phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_reg_q  <= 8'h00;
         cache_vld_q <= 1'b0;
      end else if (cen) begin
         if (state_q == ADR && scnt_q == SLAST) begin
            last_reg_q  <= cur_reg_q;
            cache_vld_q <= 1'b1;
         end
         if (tmo_hit) cache_vld_q <= 1'b0;
      end
   end
`endif

   // Next state, counters, popped command and registered bus outputs.
   always_comb begin
      state_d   = state_q;
      scnt_d    = scnt_q;
      pcnt_d    = pcnt_q;
      cur_reg_d = cur_reg_q;
      cur_val_d = cur_val_q;
      din_d     = din_q;
      addr_d    = addr_q;
      cs_n_d    = cs_n_q;
      wr_n_d    = wr_n_q;
      idle_d    = idle_q;
      pop       = 1'b0;
      start     = 1'b0;
      leave     = 1'b0;
      tmo_hit   = 1'b0;
      hit       = 1'b0;
      if (cen) begin
         case (state_q)
            IDLE: start = ~empty;
            ADR: begin
               if (scnt_q == SLAST) begin
                  state_d = GAP1;
                  scnt_d  = '0;
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            GAP1: state_d = DAT;
            DAT: begin
               if (scnt_q == SLAST) begin
                  state_d = GAP2;
                  scnt_d  = '0;
               end else begin
                  scnt_d = scnt_q + 1'b1;
               end
            end
            GAP2: begin
               state_d = POLL;
               pcnt_d  = '0;
            end
            POLL: begin
               if (!ym_dout[BUSY_BIT]) begin
                  leave = 1'b1;
               end else if (pcnt_q == PLAST) begin
                  leave   = 1'b1;
                  tmo_hit = 1'b1;
               end else begin
                  pcnt_d = pcnt_q + 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
         if (leave) begin
            state_d = IDLE;
            start   = ~empty;
         end
`ifdef JT03_SEQ_ADDR_CACHE_EN
         // A timeout on this edge invalidates the cache before the next pop.
         hit = cache_vld_q & ~tmo_hit & (head[15:8] == last_reg_q);
`endif
         if (start) begin
            pop       = 1'b1;
            cur_reg_d = head[15:8];
            cur_val_d = head[7:0];
            scnt_d    = '0;
            state_d   = hit ? DAT : ADR;
         end
         // Outputs follow the state being entered so they are glitch-free.
         case (state_d)
            ADR: begin
               cs_n_d = 1'b0;
               wr_n_d = 1'b0;
               addr_d = ADDR_PORT;
               din_d  = cur_reg_d;
            end
            DAT: begin
               cs_n_d = 1'b0;
               wr_n_d = 1'b0;
               addr_d = DATA_PORT;
               din_d  = cur_val_d;
            end
            POLL: begin
               cs_n_d = 1'b0;
               wr_n_d = 1'b1;
               addr_d = ADDR_PORT;
            end
            default: begin
               cs_n_d = 1'b1;
               wr_n_d = 1'b1;
            end
         endcase
      end
      timeout_d = timeout_q | tmo_hit;
      if (state_d == IDLE && state_q != IDLE) idle_d = 1'b1;
      if (push_acc) idle_d = 1'b0;
   end

   // State and output registers; reset releases the bus immediately.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         scnt_q    <= '0;
         pcnt_q    <= '0;
         cur_reg_q <= 8'h00;
         cur_val_q <= 8'h00;
         din_q     <= 8'h00;
         addr_q    <= ADDR_PORT;
         cs_n_q    <= 1'b1;
         wr_n_q    <= 1'b1;
         idle_q    <= 1'b1;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         scnt_q    <= scnt_d;
         pcnt_q    <= pcnt_d;
         cur_reg_q <= cur_reg_d;
         cur_val_q <= cur_val_d;
         din_q     <= din_d;
         addr_q    <= addr_d;
         cs_n_q    <= cs_n_d;
         wr_n_q    <= wr_n_d;
         idle_q    <= idle_d;
         timeout_q <= timeout_d;
      end
   end

endmodule

// File: tb/tb_jt03_wr_seq.sv
// Directed bench for jt03_wr_seq; cache checks run when
// JT03_SEQ_ADDR_CACHE_EN is defined.
module tb_jt03_wr_seq;

   logic       clk = 1'b0;
   logic       rst, cen, cmd_valid, cmd_ready;
   logic [7:0] cmd_reg, cmd_val, ym_din, ym_dout;
   logic       ym_addr, ym_cs_n, ym_wr_n, idle, timeout;

   int tests = 0;
   int errs  = 0;
   int ck    = 0;

   logic [8:0] wlog[$];
   logic       prev_stb = 1'b0;
   wire        stb = !ym_cs_n && !ym_wr_n;

   jt03_wr_seq dut (
      .clk(clk), .rst(rst), .cen(cen),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_reg(cmd_reg), .cmd_val(cmd_val),
      .ym_din(ym_din), .ym_addr(ym_addr), .ym_cs_n(ym_cs_n), .ym_wr_n(ym_wr_n),
      .ym_dout(ym_dout), .idle(idle), .timeout(timeout)
   );

   always #5 clk = ~clk;

   // Log {addr,din} at the start of every write strobe.
   always @(negedge clk) begin
      if (stb && !prev_stb) wlog.push_back({ym_addr, ym_din});
      prev_stb <= stb;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic stepc();
      cen = (ck % 3 == 0);
      ck++;
      step();
   endtask

   task automatic push(input logic [7:0] r, input logic [7:0] v);
      cmd_reg = r; cmd_val = v; cmd_valid = 1'b1;
      step();
      cmd_valid = 1'b0;
   endtask

   task automatic wait_poll(input string nm);
      int n = 0;
      while (!(ym_cs_n == 1'b0 && ym_wr_n == 1'b1) && n < 100) begin
         step(); n++;
      end
      chk(nm, int'(n < 100), 1);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (!idle && n < 2000) begin
         step(); n++;
      end
      chk(nm, int'(n < 2000), 1);
   endtask

   // Count POLL cycles starting in POLL; release busy once release_at seen.
   task automatic count_poll(input int release_at, output int pc);
      int n = 0;
      pc = 1;
      while (n < 1000) begin
         if (release_at != 0 && pc == release_at) ym_dout = 8'h00;
         step(); n++;
         if (!ym_cs_n && ym_wr_n) pc++;
         else break;
      end
   endtask

   task automatic chk_log(input string nm, input int idx, input int exp);
      chk(nm, (wlog.size() > idx) ? int'(wlog[idx]) : -1, exp);
   endtask

   typedef struct {
      logic       cs_n, wr_n, addr;
      logic [7:0] din;
      logic       idle, chk_a, chk_d;
   } vec_t;

   vec_t tv[9];
   int   pc, a_cyc, d_cyc, p_cyc;

   initial begin
      // cycle-by-cycle bus for push (0x28,0xF0), STROBE=2, busy clear
      tv[0] = '{1, 1, 0, 8'h00, 0, 0, 0};
      tv[1] = '{0, 0, 0, 8'h28, 0, 1, 1};
      tv[2] = '{0, 0, 0, 8'h28, 0, 1, 1};
      tv[3] = '{1, 1, 0, 8'h28, 0, 0, 1};
      tv[4] = '{0, 0, 1, 8'hF0, 0, 1, 1};
      tv[5] = '{0, 0, 1, 8'hF0, 0, 1, 1};
      tv[6] = '{1, 1, 0, 8'h00, 0, 0, 0};
      tv[7] = '{0, 1, 0, 8'h00, 0, 1, 0};
      tv[8] = '{1, 1, 0, 8'h00, 1, 0, 0};

      rst = 1'b1; cen = 1'b1; cmd_valid = 1'b0;
      cmd_reg = 8'h00; cmd_val = 8'h00; ym_dout = 8'h00;
      step(); step();
      chk("rst_cs_n", ym_cs_n, 1);
      chk("rst_wr_n", ym_wr_n, 1);
      chk("rst_addr", ym_addr, 0);
      chk("rst_din", ym_din, 0);
      chk("rst_idle", idle, 1);
      chk("rst_timeout", timeout, 0);
      chk("rst_ready", cmd_ready, 1);
      rst = 1'b0;
      step();

      // single write, table-driven
      push(8'h28, 8'hF0);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) step();
         chk($sformatf("t1_cs_n[%0d]", i), ym_cs_n, tv[i].cs_n);
         chk($sformatf("t1_wr_n[%0d]", i), ym_wr_n, tv[i].wr_n);
         chk($sformatf("t1_idle[%0d]", i), idle, tv[i].idle);
         if (tv[i].chk_a) chk($sformatf("t1_addr[%0d]", i), ym_addr, tv[i].addr);
         if (tv[i].chk_d) chk($sformatf("t1_din[%0d]", i), ym_din, tv[i].din);
      end

      // busy held for 10 samples then clear
      wlog.delete();
      ym_dout = 8'h80;
      push(8'h29, 8'h5A);
      wait_poll("t2_reach_poll");
      count_poll(11, pc);
      chk("t2_poll_cycles", pc, 11);
      chk("t2_idle", idle, 1);
      chk("t2_timeout", timeout, 0);
      chk("t2_nstrobes", wlog.size(), 2);
      chk_log("t2_log0", 0, 9'h029);
      chk_log("t2_log1", 1, 9'h15A);

      // FIFO full while the FSM is parked in POLL
      ym_dout = 8'h80;
      push(8'h40, 8'h00);
      wait_poll("t4_reach_poll");
      wlog.delete();
      cmd_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cmd_reg = 8'(8'h41 + k);
         cmd_val = 8'(8'hA1 + k);
         step();
         chk($sformatf("t4_ready[%0d]", k), cmd_ready, (k < 3) ? 1 : 0);
      end
      cmd_valid = 1'b0;
      chk("t4_idle_busy", idle, 0);
      ym_dout = 8'h00;
      wait_idle("t4_drain");
      chk("t4_nstrobes", wlog.size(), 8);
      for (int k = 0; k < 4; k++) begin
         chk_log($sformatf("t4_reg[%0d]", k), 2*k,   {1'b0, 8'(8'h41 + k)});
         chk_log($sformatf("t4_val[%0d]", k), 2*k+1, {1'b1, 8'(8'hA1 + k)});
      end
      chk("t4_ready_after", cmd_ready, 1);

      // busy stuck: timeout after 255 polls, next command still runs
      wlog.delete();
      ym_dout = 8'h80;
      push(8'h30, 8'h11);
      push(8'h31, 8'h22);
      wait_poll("t3_reach_poll");
      chk("t3_timeout_pre", timeout, 0);
      count_poll(0, pc);
      ym_dout = 8'h00;
      chk("t3_poll_cycles", pc, 255);
      chk("t3_timeout", timeout, 1);
      wait_idle("t3_drain");
      chk("t3_nstrobes", wlog.size(), 4);
      chk_log("t3_log0", 0, 9'h030);
      chk_log("t3_log1", 1, 9'h111);
      chk_log("t3_log2", 2, 9'h031);
      chk_log("t3_log3", 3, 9'h122);
      chk("t3_timeout_sticky", timeout, 1);

      // cen every third clk: phases measured in clk cycles
      ck = 1;
      cen = 1'b0;
      cmd_reg = 8'h50; cmd_val = 8'h55; cmd_valid = 1'b1;
      stepc();
      cmd_valid = 1'b0;
      chk("t5_push_nocen_idle", idle, 0);
      a_cyc = 0; d_cyc = 0; p_cyc = 0;
      for (int i = 0; i < 60; i++) begin
         stepc();
         if (stb && !ym_addr) a_cyc++;
         if (stb && ym_addr)  d_cyc++;
         if (!ym_cs_n && ym_wr_n) p_cyc++;
      end
      chk("t5_adr_clks", a_cyc, 6);
      chk("t5_dat_clks", d_cyc, 6);
      chk("t5_poll_clks", p_cyc, 3);
      chk("t5_idle", idle, 1);

      // reset in the middle of an address strobe
      cmd_reg = 8'h60; cmd_val = 8'h66; cmd_valid = 1'b1;
      stepc();
      cmd_reg = 8'h61; cmd_val = 8'h67;
      stepc();
      cmd_valid = 1'b0;
      begin
         int n = 0;
         while (!(stb && !ym_addr) && n < 30) begin
            stepc(); n++;
         end
         chk("t5_reach_adr", int'(n < 30), 1);
      end
      #2 rst = 1'b1;
      #1;
      chk("t5_rst_cs_n", ym_cs_n, 1);
      chk("t5_rst_wr_n", ym_wr_n, 1);
      chk("t5_rst_idle", idle, 1);
      chk("t5_rst_ready", cmd_ready, 1);
      chk("t5_rst_timeout", timeout, 0);
      step();
      rst = 1'b0;
      cen = 1'b1;
      wlog.delete();
      for (int i = 0; i < 20; i++) step();
      chk("t5_flushed", wlog.size(), 0);
      chk("t5_idle_after", idle, 1);

`ifdef JT03_SEQ_ADDR_CACHE_EN
      // repeated register skips the address phase until a timeout
      ym_dout = 8'h00;
      wlog.delete();
      push(8'h27, 8'h01);
      push(8'h27, 8'h02);
      wait_idle("c_drain1");
      chk("c_nstrobes1", wlog.size(), 3);
      chk_log("c_log0", 0, 9'h027);
      chk_log("c_log1", 1, 9'h101);
      chk_log("c_log2", 2, 9'h102);
      ym_dout = 8'h80;
      push(8'h27, 8'h03);
      wait_poll("c_reach_poll");
      count_poll(0, pc);
      ym_dout = 8'h00;
      chk("c_timeout", timeout, 1);
      wait_idle("c_drain2");
      push(8'h27, 8'h04);
      wait_idle("c_drain3");
      chk("c_nstrobes2", wlog.size(), 6);
      chk_log("c_log3", 3, 9'h103);
      chk_log("c_log4", 4, 9'h027);
      chk_log("c_log5", 5, 9'h104);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, errs);
      $finish;
   end

endmodule
